// File: rtl/bus_pkg.sv
// Shared bus definitions: serializer FSM states and default bus word width.
package bus_pkg;

   // Default word width of the FIFO-to-serializer bus.
   localparam int BUS_WIDTH = 32;

   // Serializer FSM states.
   typedef enum logic [1:0] {
      IDLE,
      POP,
      WAIT,
      SHIFT
   } ser_state_t;

endpackage

// File: rtl/bus_serializer.sv
// Pops words from the upstream FIFO and shifts them out MSB first on a
// 1-bit valid/ready serial bus, framing each word with sstart/slast.
module bus_serializer
   import bus_pkg::*;
#(
   parameter int WIDTH = BUS_WIDTH
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             fifo_empty,
   output logic             fifo_deq,
   input  logic [WIDTH-1:0] fifo_data,
   input  logic             fifo_valid,
   output logic             sdata,
   output logic             svalid,
   input  logic             sready,
   output logic             sstart,
   output logic             slast,
   output logic             busy
);

   localparam int               CNT_W   = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

   ser_state_t       state;
   ser_state_t       state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [CNT_W-1:0] cnt;

   // State register; reset abandons any word in flight.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values, whatever the block order.
         state <= state_nxt;
      end
   end

   // Next-state decode; outputs depend only on state, cnt and shreg.
   always_comb begin
      // NOTE: every output gets a default first, so no path through the case can infer a latch.
      state_nxt = state;
      fifo_deq  = 1'b0;
      svalid    = 1'b0;
      sdata     = 1'b0;
      sstart    = 1'b0;
      slast     = 1'b0;
      busy      = (state != IDLE);

      case (state)
         IDLE: begin
            if (!fifo_empty) state_nxt = POP;
         end
         POP: begin
            // Single-cycle pop request; at most one pop outstanding.
            fifo_deq  = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            // A refused pop leaves the word in the FIFO; go back and retry.
            state_nxt = fifo_valid ? SHIFT : IDLE;
         end
         SHIFT: begin
            svalid = 1'b1;
            sdata  = shreg[WIDTH-1];
            sstart = (cnt == CNT_MAX);
            slast  = (cnt == '0);
            if (sready && (cnt == '0)) begin
               // Skip IDLE when another word is already waiting.
               state_nxt = fifo_empty ? IDLE : POP;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Shift register and bit counter: load on accepted pop, shift on handshake.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         // NOTE: datapath is reset too, so a word cut off by reset never leaks into the next frame.
         shreg <= '0;
         cnt   <= '0;
      end else if ((state == WAIT) && fifo_valid) begin
         shreg <= fifo_data;
         cnt   <= CNT_MAX;
      end else if ((state == SHIFT) && sready) begin
         shreg <= {shreg[WIDTH-2:0], 1'b0};
         // Hold at zero after the last bit rather than wrapping.
         if (cnt != '0) cnt <= cnt - CNT_W'(1);
      end
   end

endmodule
